seq_detect_param: RTL
=====================

# seq_detect_param

Parametrised Moore serial pattern detector for single-bit input streams. It supersedes the fixed-pattern `1011` detector. Pattern width, pattern value, overlap mode and match-counter width are elaboration-time parameters. It adds a sample-enable qualifier, a saturating match counter with synchronous clear, and a saturation flag. It sits between a serial bit source and status logic that either polls the match count or reacts to the detect pulse.

## Interface
- `PAT_W`, 4: pattern length in bits. Legal range 2..16.
- `PATTERN`, 4'b1011: pattern to detect, `PAT_W` bits wide. The MSB is the first bit received.
- `OVERLAP`, 1: 1 = overlapping matches allowed; 0 = detector restarts from empty after each match.
- `CNT_W`, 8: match-counter width. Legal range 1..32.

Ports:
- `CK`, input, 1: clock, rising-edge active. One clock domain only.
- `R`, input, 1: reset, asynchronous, active-high.
- `IN`, input, 1: serial data bit, sampled at posedge `CK` when `EN`=1.
- `EN`, input, 1: sample qualifier. When 0, `IN` is ignored and all state holds.
- `CLR`, input, 1: synchronous clear of `OUT` and `SAT`. Does not affect detector state.
- `DET`, output, 1: Moore detect output. 1 while the detector is in the full-match state.
- `MATCH`, output, 1: registered one-cycle pulse on the edge that enters the full-match state.
- `OUT`, output, `CNT_W`: saturating count of matches since reset or `CLR`.
- `SAT`, output, 1: sticky flag. Set when `OUT` is at all-ones and a further match occurs.

## Operation
- The state register `S` holds the number of pattern bits currently matched, 0..`PAT_W`. Width is clog2(`PAT_W`+1).
- The next-state function is KMP style:
  - From state k<`PAT_W`: if `IN` equals pattern bit k (counted from the MSB), go to k+1. Otherwise go to the longest proper prefix of (matched prefix followed by `IN`) that is also a suffix of that string.
  - From state `PAT_W` with `OVERLAP`=1: behave as state f(`PAT_W`), the failure value. For 1011, f=1.
  - From state `PAT_W` with `OVERLAP`=0: behave as state 0.
- Transition and failure tables are computed at elaboration with a function or generate loop. There are no runtime pattern registers.
- `DET` = (`S` == `PAT_W`). It is decoded from the registered state, so it has no combinational path from `IN`.
- `MATCH` is registered. It is 1 for exactly one cycle after each edge at which `S` transitions into `PAT_W` with `EN`=1. A match-to-match transition (overlapping, e.g. pattern 11 with input 1,1,1) counts as a new entry.
- Counter rules, evaluated at each posedge `CK`:
  - `CLR`=1 and no match: `OUT`←0, `SAT`←0.
  - `CLR`=1 and a match on the same edge: `OUT`←1, `SAT`←0. The match is not lost.
  - Match and `OUT`≠all-ones: `OUT`←`OUT`+1.
  - Match and `OUT`=all-ones: `OUT` holds and `SAT`←1.
- `EN`=0: `S`, `MATCH`←0, and `DET` hold state. `CLR` is still honoured.
- Reset values: `S`=0, `DET`=0, `MATCH`=0, `OUT`=0, `SAT`=0. These apply immediately on assertion of `R`, regardless of clock.
- Reset mid-pattern discards the partial match. After release, detection starts from an empty history.

## Timing
- Latency: the final pattern bit is sampled at edge n. `DET` and `MATCH` go high and `OUT` updates after edge n, all visible in the same cycle.
- `DET` stays high through `EN`=0 cycles. It drops after the next qualified sample that does not re-enter the full-match state.
- `R` is released synchronously by the integrating design. The block itself only requires `R` to be low at least 1 cycle before the first qualified sample.
- The worst-case combinational path is the `IN` → next-state mux → `S` register. There is no path from `IN` to any output.

## Test plan
- Reset, then `IN`=1,0,1,1 with `EN`=1, defaults → `DET`=1 and `MATCH`=1 for 1 cycle after the 4th edge, `OUT`=1.
- `OVERLAP`=1, `IN`=1,0,1,1,0,1,1 → two `MATCH` pulses, after bits 4 and 7, `OUT`=2. Same stream with `OVERLAP`=0 → one pulse, after bit 4, `OUT`=1.
- Stream 1,0,1 then `EN`=0 for 3 cycles with `IN` toggling, then `EN`=1, `IN`=1 → match on that edge, `OUT`=1. `DET` holds high through a further 2 cycles of `EN`=0.
- `CNT_W`=2: 5 consecutive matches → `OUT`=3, `SAT`=1. Then `CLR` asserted on the same edge as a 6th match → `OUT`=1, `SAT`=0.
- Assert `R` asynchronously mid-cycle after 1,0,1, hold it for 2 edges, release, then drive `IN`=1 → `DET`=0, `OUT`=0. No match until a full 1,0,1,1 is received.
- `PAT_W`=6, `PATTERN`=6'b110110, `OVERLAP`=1, stream 1,1,0,1,1,0,1,1,0 → matches after bits 6 and 9, `OUT`=2.

Source files
------------

// File: rtl/seq_detect_param.sv
// Parametrised Moore serial pattern detector with a KMP-style next-state table
// built at elaboration, a registered match pulse and a saturating match counter.
module seq_detect_param #(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             CK,
  input  logic             R,
  input  logic             IN,
  input  logic             EN,
  input  logic             CLR,
  output logic             DET,
  output logic             MATCH,
  output logic [CNT_W-1:0] OUT,
  output logic             SAT
);

  localparam int unsigned      SW      = $clog2(PAT_W + 1);
  localparam logic [SW-1:0]    FULL    = SW'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Pattern bit i counted from the first bit received (the MSB).
  function automatic bit pat_bit(int unsigned i);
    return PATTERN[PAT_W-1-i];
  endfunction

  // Longest pattern prefix that is a suffix of (first k pattern bits, then b).
  // Includes the full extension k+1 when b matches pattern bit k.
  function automatic int unsigned delta(int unsigned k, bit b);
    int unsigned res;
    int unsigned j;
    bit          ok;
    bit          sb;
    res = 0;
    for (int unsigned l = 1; l <= k + 1; l++) begin
      ok = 1'b1;
      for (int unsigned i = 0; i < l; i++) begin
        j  = k + 1 - l + i;
        sb = (j < k) ? pat_bit(j) : b;
        if (sb != pat_bit(i)) ok = 1'b0;
      end
      if (ok) res = l;
    end
    return res;
  endfunction

  // Failure value of the full-match state: longest proper border of the pattern.
  function automatic int unsigned fail_full();
    int unsigned res;
    bit          ok;
    res = 0;
    for (int unsigned l = 1; l < PAT_W; l++) begin
      ok = 1'b1;
      for (int unsigned i = 0; i < l; i++) begin
        if (pat_bit(i) != pat_bit(PAT_W - l + i)) ok = 1'b0;
      end
      if (ok) res = l;
    end
    return res;
  endfunction

  // Non-overlapping mode restarts from the empty history after a match.
  localparam int unsigned F_FULL = OVERLAP ? fail_full() : 0;

  logic [SW-1:0]    nxt0 [PAT_W+1];
  logic [SW-1:0]    nxt1 [PAT_W+1];
  logic [SW-1:0]    state_q;
  logic [SW-1:0]    state_d;
  logic             match_ev;
  logic             match_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;

  // Constant transition table; the full-match row reuses the row of its failure state.
  for (genvar k = 0; k <= int'(PAT_W); k++) begin : g_tab
    localparam int unsigned KE = (k == int'(PAT_W)) ? F_FULL : k;
    assign nxt0[k] = SW'(delta(KE, 1'b0));
    assign nxt1[k] = SW'(delta(KE, 1'b1));
  end

  // State register: number of pattern bits currently matched.
  always_ff @(posedge CK or posedge R) begin
    if (R) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: table lookup on qualified samples, hold otherwise.
  always_comb begin
    state_d  = state_q;
    if (EN) begin
      state_d = IN ? nxt1[state_q] : nxt0[state_q];
    end
    match_ev = EN && (state_d == FULL);
  end

  // Moore output decoded from the registered state only.
  always_comb begin
    DET = (state_q == FULL);
  end

  // Match pulse and saturating counter; a clear coinciding with a match keeps that match.
  always_ff @(posedge CK or posedge R) begin
    if (R) begin
      match_q <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      match_q <= match_ev;
      if (CLR) begin
        cnt_q <= match_ev ? CNT_W'(1) : '0;
        sat_q <= 1'b0;
      end else if (match_ev) begin
        if (cnt_q == CNT_MAX) begin
          sat_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign MATCH = match_q;
  assign OUT   = cnt_q;
  assign SAT   = sat_q;

endmodule
